// File: rtl/img_pkg.sv
// Shared image-receive constants and the receiver state type.
package img_pkg;
    localparam int IMG_DIM_W = 8;
    localparam int PIX_W     = 8;

    typedef enum logic {IDLE, RECV} rx_state_t;
endpackage

// File: rtl/img_addr_counter.sv
// Row-major address walker over an nrows x ncols image; last flags the final pixel.
module img_addr_counter
    import img_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    input  logic [IMG_DIM_W-1:0] nrows,
    input  logic [IMG_DIM_W-1:0] ncols,
    output logic [IMG_DIM_W-1:0] row,
    output logic [IMG_DIM_W-1:0] col,
    output logic                 last
);
    localparam logic [IMG_DIM_W-1:0] ONE = IMG_DIM_W'(1);

    logic col_wrap;

    assign col_wrap = (col == ncols - ONE);
    assign last     = (row == nrows - ONE) && col_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col_wrap) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end
endmodule

// File: rtl/io_rx_controller.sv
// Streams a row-major pixel frame into SRAM, one registered write per clock.
// Optional sticky overrun flag is built when IO_RX_OVERRUN_EN is defined.
module io_rx_controller
    import img_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IMG_DIM_W-1:0] nrows,
    input  logic [IMG_DIM_W-1:0] ncols,
    input  logic [PIX_W-1:0]     din,
    output logic                 busy,
    output logic [IMG_DIM_W-1:0] sram_row,
    output logic [IMG_DIM_W-1:0] sram_col,
    output logic [PIX_W-1:0]     sram_din,
    output logic                 sram_write_en,
    output logic                 sram_sense_en,
    input  logic [PIX_W-1:0]     sram_dout
`ifdef IO_RX_OVERRUN_EN
    ,
    output logic                 overrun
`endif
);
    rx_state_t state, state_next;
    logic      clear, step, start, last;
    logic      unused_sram_dout;

    assign unused_sram_dout = ^sram_dout;

    img_addr_counter u_addr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .step  (step),
        .nrows (nrows),
        .ncols (ncols),
        .row   (sram_row),
        .col   (sram_col),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        step       = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (en && (nrows != '0) && (ncols != '0)) begin
                    state_next = RECV;
                    start      = 1'b1;
                    clear      = 1'b1;
                end
            end
            RECV: begin
                if (last) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs follow the next state so every write is presented from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy          <= 1'b0;
            sram_din      <= '0;
            sram_write_en <= 1'b0;
            sram_sense_en <= 1'b1;
        end else begin
            busy          <= (state_next == RECV);
            sram_write_en <= (state_next == RECV);
            sram_sense_en <= (state_next != RECV);
            sram_din      <= (state_next == RECV) ? din : '0;
        end
    end

`ifdef IO_RX_OVERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        overrun <= 1'b0;
        else if (start)                 overrun <= 1'b0;
        else if (state == RECV && en)   overrun <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_io_rx_controller.sv
// Randomized self-checking bench for io_rx_controller against a frame-level model.
// Define IO_RX_OVERRUN_EN to also check the overrun flag.
module tb_io_rx_controller;
    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] nrows, ncols, din, sram_dout;
    logic       busy, sram_write_en, sram_sense_en;
    logic [7:0] sram_row, sram_col, sram_din;
`ifdef IO_RX_OVERRUN_EN
    logic       overrun;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Frame-level reference model: which pixel index is on the SRAM port.
    bit  m_busy = 1'b0;
    bit  m_ovr = 1'b0;
    int  m_idx = 0, m_total = 0, m_nc = 1;
    byte unsigned m_data = 0;

    int write_count = 0, busy_cycles = 0;
    logic [7:0]   mem [0:65535];
    byte unsigned pix [0:16383];

    always #5 clk = ~clk;

    io_rx_controller dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .nrows         (nrows),
        .ncols         (ncols),
        .din           (din),
        .busy          (busy),
        .sram_row      (sram_row),
        .sram_col      (sram_col),
        .sram_din      (sram_din),
        .sram_write_en (sram_write_en),
        .sram_sense_en (sram_sense_en),
        .sram_dout     (sram_dout)
`ifdef IO_RX_OVERRUN_EN
        ,
        .overrun       (overrun)
`endif
    );

    task automatic checkOutput(input string tag, input int unsigned actual, input int unsigned expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("busy", busy, m_busy);
        checkOutput("write_en", sram_write_en, m_busy);
        checkOutput("sense_en", sram_sense_en, !m_busy);
        checkOutput("row", sram_row, m_busy ? m_idx / m_nc : 0);
        checkOutput("col", sram_col, m_busy ? m_idx % m_nc : 0);
        checkOutput("data", sram_din, m_busy ? m_data : 0);
`ifdef IO_RX_OVERRUN_EN
        checkOutput("overrun", overrun, m_ovr);
`endif
        if (sram_write_en === 1'b1) begin
            mem[{sram_row, sram_col}] = sram_din;
            write_count++;
        end
        if (busy === 1'b1) busy_cycles++;
    endtask

    task automatic modelReset();
        m_busy = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic applyStimulus(input bit e, input byte unsigned d);
        en  = e;
        din = d;
        @(posedge clk);
        if (m_busy) begin
            if (e) m_ovr = 1'b1;
            if (m_idx == m_total - 1) m_busy = 1'b0;
            else begin
                m_idx++;
                m_data = d;
            end
        end else if (e && nrows != 0 && ncols != 0) begin
            m_busy  = 1'b1;
            m_idx   = 0;
            m_total = nrows * ncols;
            m_nc    = ncols;
            m_data  = d;
            m_ovr   = 1'b0;
        end
        @(negedge clk);
        checkModel();
    endtask

    // Runs one frame; base < 0 means random pixels, spur marks extra en cycles.
    task automatic runFrame(input int nr, input int nc, input int base, input logic [31:0] spur);
        int total, bad;
        bit e;
        total = nr * nc;
        nrows = 8'(nr);
        ncols = 8'(nc);
        write_count = 0;
        busy_cycles = 0;
        for (int i = 0; i < total; i++) begin
            pix[i] = (base < 0) ? 8'($urandom) : 8'(base + i);
            mem[{8'(i / nc), 8'(i % nc)}] = 'x;
        end
        for (int i = 0; i <= total + 1; i++) begin
            e = (i == 0) || (i <= total && i < 32 && spur[i]);
            applyStimulus(e, (i < total) ? pix[i] : 8'($urandom));
        end
        checkOutput("write_count", write_count, total);
        checkOutput("busy_cycles", busy_cycles, total);
        bad = 0;
        for (int i = 0; i < total; i++)
            if (mem[{8'(i / nc), 8'(i % nc)}] !== pix[i]) bad++;
        checkOutput("readback_errors", bad, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = 8'h00; nrows = 8'd0; ncols = 8'd0; sram_dout = 8'h5A;
        #1;
        checkModel();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00);

        runFrame(2, 3, 8'h10, 32'h0);
        checkOutput("pix_1_2", mem[{8'd1, 8'd2}], 8'h15);
        checkOutput("pix_0_1", mem[{8'd0, 8'd1}], 8'h11);

        runFrame(2, 3, -1, 32'h44);
`ifdef IO_RX_OVERRUN_EN
        checkOutput("overrun_sticky", overrun, 1);
`endif

        // Abort a 4x4 frame after five writes, then restart cleanly.
        nrows = 8'd4; ncols = 8'd4; write_count = 0;
        for (int i = 0; i < 5; i++) applyStimulus(i == 0, 8'(8'h20 + i));
        checkOutput("pre_abort_writes", write_count, 5);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_write_en", sram_write_en, 0);
        checkOutput("abort_sense_en", sram_sense_en, 1);
        checkOutput("abort_col", sram_col, 0);
        @(negedge clk);
        rst = 1'b0;
        checkModel();
        runFrame(4, 4, -1, 32'h0);

        nrows = 8'd0; ncols = 8'd8; write_count = 0; busy_cycles = 0;
        applyStimulus(1'b1, 8'h77);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("zero_rows_writes", write_count, 0);
        checkOutput("zero_rows_busy", busy_cycles, 0);

        runFrame(1, 1, 8'hA5, 32'h0);
        checkOutput("single_pix", mem[{8'd0, 8'd0}], 8'hA5);

        for (int k = 0; k < 8; k++)
            runFrame($urandom_range(1, 8), $urandom_range(1, 8), -1,
                     $urandom & $urandom & $urandom & 32'hFFFF_FFFE);

        runFrame(255, 1, -1, 32'h0);
        runFrame(128, 128, -1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/io_rx_controller.md
IO_RX_CONTROLLER -- requirements
Module: io_rx_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  start strobe, sampled on the rising edge of clk.
REQ-005 nrows  input  8  image row count, valid 1..255, held stable while busy.
REQ-006 ncols  input  8  image column count, valid 1..255, held stable while busy.
REQ-007 din  input  8  pixel byte stream, one pixel per clock, row-major order.
REQ-008 busy  output  1  high while a frame is being received.
REQ-009 sram_row  output  8  SRAM row address.
REQ-010 sram_col  output  8  SRAM column address.
REQ-011 sram_din  output  8  SRAM write data.
REQ-012 sram_write_en  output  1  SRAM write strobe, active high.
REQ-013 sram_sense_en  output  1  SRAM read-sense enable, active high.
REQ-014 sram_dout  input  8  SRAM read data; the block SHALL ignore it.

Function
REQ-015 The block SHALL implement two states: IDLE and RECV.
REQ-016 The IDLE to RECV transition SHALL occur on a clock edge in IDLE where en=1, nrows!=0 and ncols!=0.
- At that edge: sram_row=0, sram_col=0, sram_din=din, sram_write_en=1, sram_sense_en=0, busy=1.
REQ-017 The byte on din in the en cycle SHALL be pixel (0,0).
- Each following cycle's din SHALL be the next pixel in row-major order.
REQ-018 On each edge in RECV that is not the last pixel, the block SHALL:
- register din into sram_din;
- increment sram_col;
- when sram_col = ncols-1, set sram_col to 0 and increment sram_row.
REQ-019 On the edge after the write of (nrows-1, ncols-1) is presented, the block SHALL:
- drive sram_write_en=0, sram_sense_en=1 and busy=0;
- return to IDLE.
REQ-020 Latency SHALL be as follows.
- The first SRAM write SHALL be presented 1 cycle after en is sampled.
- busy SHALL be high for exactly nrows*ncols cycles.
REQ-021 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-022 en SHALL be ignored while busy=1, including in the last-pixel cycle.
REQ-023 en with nrows=0 or ncols=0 SHALL be ignored.
REQ-024 In IDLE the SRAM outputs SHALL be held at sram_row=0, sram_col=0, sram_din=0, sram_write_en=0, sram_sense_en=1.
REQ-025 Address arithmetic SHALL be 8-bit unsigned; no address SHALL ever exceed nrows-1 or ncols-1.

Reset
REQ-026 While rst=1 the block SHALL immediately force the following, independent of clk:
- state=IDLE, busy=0;
- sram_write_en=0, sram_sense_en=1;
- sram_row=0, sram_col=0, sram_din=0.
REQ-027 Reset asserted during RECV SHALL abort the frame with no further writes, and SHALL leave no residual state.

Configuration
REQ-028 When macro IO_RX_OVERRUN_EN is defined, the block SHALL add output overrun (1 bit, reset 0).
- overrun SHALL set when en=1 is sampled while busy=1.
- overrun SHALL clear on the next accepted start or on reset.
REQ-029 When IO_RX_OVERRUN_EN is undefined, the overrun port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Shared package img_pkg SHALL hold:
- constants IMG_DIM_W=8 and PIX_W=8;
- the rx_state_t enum {IDLE, RECV}.
REQ-031 The row/column walker SHALL be one sub-module, img_addr_counter.
- Inputs: clear and step.
- Outputs: row, col and last, where last=(row=nrows-1 and col=ncols-1).

Verification
REQ-032 Scenario: nrows=ncols=128, en pulsed with din=image[0], then image[1..16383] on consecutive cycles -> 16384 writes at (i/128, i%128) with data image[i]; busy high for 16384 cycles; a readback matches.
REQ-033 Scenario: nrows=2, ncols=3, din=0x10..0x15 -> writes (0,0)=0x10, (0,1)=0x11, (0,2)=0x12, (1,0)=0x13, (1,1)=0x14, (1,2)=0x15; busy falls 6 cycles after start.
REQ-034 Scenario: en re-pulsed mid-frame and in the last-pixel cycle (2x3 frame) -> no restart; write count stays 6; with IO_RX_OVERRUN_EN, overrun=1.
REQ-035 Scenario: rst pulsed after 5 writes of a 4x4 frame -> busy=0, sram_write_en=0 immediately; a new en restarts at (0,0).
REQ-036 Scenario: en with nrows=0, ncols=8 -> busy stays 0; no writes.
REQ-037 Scenario: nrows=1, ncols=1, din=0xA5 -> a single write (0,0)=0xA5; busy high exactly 1 cycle.
